led4_scan_ctrl: RTL

LED4_SCAN_CTRL -- requirements
Module: led4_scan_ctrl

---
 rtl/led4_scan_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/led4_scan_ctrl.sv
// 4-digit BCD counter with a multiplexed active-low 7-segment scan; Value moves 3 clocks after a synchronized
// Clk_20Hz rise, display outputs lag the scan FSM by one clock. Macro LED4_LEADING_ZERO_BLANK_EN blanks leading zeros.
module led4_scan_ctrl #(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 50,
    parameter int DP_POS    = 4
) (
    input  logic        Clk_50MHz,
    input  logic        Reset,
    input  logic        Clk_20Hz,
    input  logic        Clk_20kHz,
    input  logic        Count_En,
    input  logic        Count_Clr,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic [3:0]  Digit,
    output logic [15:0] Value,
    output logic        Carry
);

    typedef enum logic {ST_SHOW, ST_BLANK} state_t;

    logic [2:0]  r_s20;
    logic [2:0]  r_s20k;
    logic        r_tick20;
    logic        r_tick20k;
    logic [15:0] r_value;
    logic        r_carry;
    logic [7:0]  r_pre;
    logic        r_adv;
    state_t      r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_bcnt;
    logic [6:0]  r_seg;
    logic        r_dp;
    logic [3:0]  r_digit;

    logic [15:0] w_value_inc;
    logic        w_chain;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg_dec;
    logic        w_lz;

    // Bits [1:0] synchronize, bit [2] is the history used for rise detection.
    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            r_s20     <= 3'b000;
            r_s20k    <= 3'b000;
            r_tick20  <= 1'b0;
            r_tick20k <= 1'b0;
        end else begin
            r_s20     <= {r_s20[1:0], Clk_20Hz};
            r_s20k    <= {r_s20k[1:0], Clk_20kHz};
            r_tick20  <= r_s20[1] & ~r_s20[2];
            r_tick20k <= r_s20k[1] & ~r_s20k[2];
        end
    end

    always_comb begin
        w_value_inc = r_value;
        w_chain     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_chain) begin
                if (r_value[4*i +: 4] >= 4'd9) begin
                    w_value_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_value_inc[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                    w_chain               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            r_value <= 16'h0000;
            r_carry <= 1'b0;
        end else if (Count_Clr) begin
            r_value <= 16'h0000;
            r_carry <= 1'b0;
        end else if (r_tick20 && Count_En) begin
            r_value <= w_value_inc;
            r_carry <= (r_value == 16'h9999);
        end else begin
            r_carry <= 1'b0;
        end
    end

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            r_pre <= 8'd0;
            r_adv <= 1'b0;
        end else if (r_tick20k) begin
            if (r_pre == 8'(SCAN_DIV - 1)) begin
                r_pre <= 8'd0;
                r_adv <= 1'b1;
            end else begin
                r_pre <= r_pre + 8'd1;
                r_adv <= 1'b0;
            end
        end else begin
            r_adv <= 1'b0;
        end
    end

    // Advance requests seen in BLANK fall through the default hold and are lost.
    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_BLANK;
            r_idx   <= 2'd3;
            r_bcnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_SHOW: begin
                    if (r_adv) begin
                        r_state <= ST_BLANK;
                        r_bcnt  <= 8'd0;
                    end
                end
                default: begin
                    if (r_bcnt == 8'(BLANK_CYC - 1)) begin
                        r_state <= ST_SHOW;
                        r_idx   <= r_idx + 2'd1;
                        r_bcnt  <= 8'd0;
                    end else begin
                        r_bcnt  <= r_bcnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign w_nib = r_value[{r_idx, 2'b00} +: 4];

    always_comb begin
        case (w_nib)
            4'd0:    w_seg_dec = 7'h40;
            4'd1:    w_seg_dec = 7'h79;
            4'd2:    w_seg_dec = 7'h24;
            4'd3:    w_seg_dec = 7'h30;
            4'd4:    w_seg_dec = 7'h19;
            4'd5:    w_seg_dec = 7'h12;
            4'd6:    w_seg_dec = 7'h02;
            4'd7:    w_seg_dec = 7'h78;
            4'd8:    w_seg_dec = 7'h00;
            4'd9:    w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h7F;
        endcase
    end

`ifdef LED4_LEADING_ZERO_BLANK_EN
    always_comb begin
        case (r_idx)
            2'd1:    w_lz = (r_value[15:4] == 12'h000);
            2'd2:    w_lz = (r_value[15:8] == 8'h00);
            2'd3:    w_lz = (r_value[15:12] == 4'h0);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    always_ff @(posedge Clk_50MHz or posedge Reset) begin
        if (Reset) begin
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_digit <= 4'hF;
        end else if (r_state == ST_SHOW) begin
            r_seg   <= w_lz ? 7'h7F : w_seg_dec;
            r_dp    <= ({1'b0, r_idx} == 3'(DP_POS)) ? 1'b0 : 1'b1;
            r_digit <= ~(4'b0001 << r_idx);
        end else begin
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_digit <= 4'hF;
        end
    end

    assign Seg   = r_seg;
    assign Dp    = r_dp;
    assign Digit = r_digit;
    assign Value = r_value;
    assign Carry = r_carry;

endmodule
